// File: rtl/ddio_out_burst_tx_if.sv
// Handshake and pad-side bundle for ddio_out_burst_tx.
// The core drives the master side; the transmitter sits on the slave side.
interface ddio_out_burst_tx_if #(
   parameter int unsigned WIDTH = 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data_h;
   logic [WIDTH-1:0] in_data_l;
   logic [WIDTH-1:0] dataout_h;
   logic [WIDTH-1:0] dataout_l;
   logic             oe;
   logic             busy;
   logic             burst_done;

   modport master (
      output in_valid, in_data_h, in_data_l,
      input  in_ready, dataout_h, dataout_l, oe, busy, burst_done
   );

   modport slave (
      input  in_valid, in_data_h, in_data_l,
      output in_ready, dataout_h, dataout_l, oe, busy, burst_done
   );
endinterface

// File: rtl/ddio_out_burst_tx.sv
// Buffers high/low word pairs and plays them onto DDIO output-register inputs
// inside an output-enable window: preamble, back-to-back data, postamble.
module ddio_out_burst_tx #(
   parameter int unsigned     WIDTH            = 1,
   parameter int unsigned     DEPTH            = 4,
   parameter int unsigned     PREAMBLE_CYCLES  = 1,
   parameter int unsigned     POSTAMBLE_CYCLES = 1,
   parameter logic [WIDTH-1:0] IDLE_VALUE      = '0
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               clkena,
   ddio_out_burst_tx_if.slave bus_io
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [3:0]  PreLoad  = 4'((PREAMBLE_CYCLES > 0) ? PREAMBLE_CYCLES - 1 : 0);
   localparam logic [3:0]  PostLoad = 4'((POSTAMBLE_CYCLES > 0) ? POSTAMBLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {StIdle, StPre, StData, StPost} state_e;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q;
   logic [2*WIDTH-1:0]   mem_q [DEPTH];
   logic [WIDTH-1:0]     dh_q, dh_d, dl_q, dl_d;
   logic                 oe_q, oe_d, done_q, done_d;
   logic                 pop, wr_en, in_ready, empty, full;
   logic [2*WIDTH-1:0]   head;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CntW'(DEPTH));
   assign in_ready = !full && !areset;
   assign wr_en    = bus_io.in_valid && in_ready && clkena;
   assign head     = mem_q[rd_ptr_q];

   assign bus_io.in_ready   = in_ready;
   assign bus_io.dataout_h  = dh_q;
   assign bus_io.dataout_l  = dl_q;
   assign bus_io.oe         = oe_q;
   assign bus_io.busy       = (state_q != StIdle);
   assign bus_io.burst_done = done_q;

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {bus_io.in_data_h, bus_io.in_data_l};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oe_d    = oe_q;
      dh_d    = dh_q;
      dl_d    = dl_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               oe_d = 1'b1;
               if (PREAMBLE_CYCLES > 0) begin
                  state_d = StPre;
                  cnt_d   = PreLoad;
               end else begin
                  pop     = 1'b1;
                  state_d = StData;
               end
            end
         end
         StPre: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               pop     = 1'b1;
               state_d = StData;
            end
         end
         StData: begin
            if (!empty) begin
               pop = 1'b1;
            end else begin
               dh_d = IDLE_VALUE;
               dl_d = IDLE_VALUE;
               if (POSTAMBLE_CYCLES > 0) begin
                  state_d = StPost;
                  cnt_d   = PostLoad;
               end else begin
                  oe_d    = 1'b0;
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         StPost: begin
            // A late word resumes the burst without a fresh preamble.
            if (!empty) begin
               pop     = 1'b1;
               state_d = StData;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               oe_d    = 1'b0;
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (pop) begin
         {dh_d, dl_d} = head;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dh_q     <= IDLE_VALUE;
         dl_q     <= IDLE_VALUE;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
      end else if (clkena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dh_q    <= dh_d;
         dl_q    <= dl_d;
         oe_q    <= oe_d;
         done_q  <= done_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(wr_en) - CntW'(pop);
      end
   end
endmodule
